// File: rtl/booth_mul_ctrl_if.sv
// Handshake bus for booth_mul_ctrl: operand issue on one side, product return on the other.
interface booth_mul_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  multiplier;
  logic [7:0]  multiplicand;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        out_err;
  logic        busy;

  modport master (
    output in_valid, multiplier, multiplicand, out_ready,
    input  in_ready, out_valid, product, out_err, busy
  );

  modport slave (
    input  in_valid, multiplier, multiplicand, out_ready,
    output in_ready, out_valid, product, out_err, busy
  );
endinterface

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth 8x8 signed multiply sequencer; STEPS_PER_CYCLE substeps per clock.
// Optional BOOTH_SKIP_ZERO_EN: zero operands bypass RUN and return 0 directly.
module booth_mul_ctrl #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic             clk,
  input logic             rst,
  booth_mul_ctrl_if.slave bus
);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2)) begin : g_bad_steps
    $error("booth_mul_ctrl: STEPS_PER_CYCLE must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_acc;
  logic [7:0]  r_q;
  logic        r_qm1;
  logic [7:0]  r_mcand;
  logic [3:0]  r_cnt;
  logic [15:0] r_prod;
  logic        r_err;

  logic [16:0] w_chain [0:STEPS_PER_CYCLE];
  logic [3:0]  w_cnt_nxt;
  logic        w_skip;

  // One Booth substep on {acc,Q,q(-1)}: add/sub by the Q[0],q(-1) pair, then arithmetic shift.
  function automatic logic [16:0] substep(input logic [16:0] s, input logic [7:0] m);
    logic [7:0] a;
    a = s[16:9];
    case (s[1:0])
      2'b10:   a = a - m;
      2'b01:   a = a + m;
      default: a = s[16:9];
    endcase
    return {a[7], a, s[8:1]};
  endfunction

  always_comb begin
    w_chain[0] = {r_acc, r_q, r_qm1};
    for (int k = 0; k < STEPS_PER_CYCLE; k++)
      w_chain[k+1] = substep(w_chain[k], r_mcand);
  end

  assign w_cnt_nxt = r_cnt + 4'(STEPS_PER_CYCLE);

`ifdef BOOTH_SKIP_ZERO_EN
  assign w_skip = (bus.multiplier == 8'h00) || (bus.multiplicand == 8'h00);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_acc   <= '0;
          r_q     <= bus.multiplier;
          r_qm1   <= 1'b0;
          r_mcand <= bus.multiplicand;
          r_cnt   <= '0;
          if (w_skip) begin
            r_prod  <= '0;
            r_err   <= 1'b0;
            r_state <= DONE;
          end else begin
            r_err   <= (bus.multiplicand == 8'h80);
            r_state <= RUN;
          end
        end
        RUN: begin
          {r_acc, r_q, r_qm1} <= w_chain[STEPS_PER_CYCLE];
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == 4'd8) begin
            r_prod  <= w_chain[STEPS_PER_CYCLE][16:1];
            r_state <= DONE;
          end
        end
        DONE: if (bus.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.product   = r_prod;
  assign bus.out_err   = r_err;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Bench for booth_mul_ctrl: one- and two-step instances share stimulus, checked against signed arithmetic.
module tb_booth_mul_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

`ifdef BOOTH_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  booth_mul_ctrl_if b0 ();
  booth_mul_ctrl_if b1 ();

  assign b1.in_valid     = b0.in_valid;
  assign b1.multiplier   = b0.multiplier;
  assign b1.multiplicand = b0.multiplicand;
  assign b1.out_ready    = b0.out_ready;

  booth_mul_ctrl #(.STEPS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b0));
  booth_mul_ctrl #(.STEPS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation with out_ready high; measure latency, pulse width, product and err.
  task automatic op(input logic [7:0] mpr, input logic [7:0] mcd, input string tag);
    int lat0, lat1, hi0, hi1, refp, el0, el1;
    logic [15:0] p0, p1;
    logic e0, e1;
    bit zero;
    lat0 = -1; lat1 = -1; hi0 = 0; hi1 = 0;
    p0 = '0; p1 = '0; e0 = 1'b0; e1 = 1'b0;
    chk({tag, " in_ready1"}, 32'(b0.in_ready), 32'd1);
    chk({tag, " in_ready2"}, 32'(b1.in_ready), 32'd1);
    b0.in_valid = 1'b1; b0.multiplier = mpr; b0.multiplicand = mcd;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    b0.multiplier = 8'($urandom); b0.multiplicand = 8'($urandom);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (b0.out_valid) begin
        hi0++;
        if (lat0 < 0) begin lat0 = k; p0 = b0.product; e0 = b0.out_err; end
      end
      if (b1.out_valid) begin
        hi1++;
        if (lat1 < 0) begin lat1 = k; p1 = b1.product; e1 = b1.out_err; end
      end
    end
    zero = SKIP && (mpr == 8'h00 || mcd == 8'h00);
    el0 = zero ? 1 : 8;
    el1 = zero ? 1 : 4;
    refp = $signed(mpr) * $signed(mcd);
    chk({tag, " lat1"}, 32'(lat0), 32'(el0));
    chk({tag, " lat2"}, 32'(lat1), 32'(el1));
    chk({tag, " pulse1"}, 32'(hi0), 32'd1);
    chk({tag, " pulse2"}, 32'(hi1), 32'd1);
    if (mcd != 8'h80) begin
      chk({tag, " prod1"}, 32'(p0), 32'(refp[15:0]));
      chk({tag, " prod2"}, 32'(p1), 32'(refp[15:0]));
    end
    chk({tag, " err1"}, 32'(e0), 32'(mcd == 8'h80));
    chk({tag, " err2"}, 32'(e1), 32'(mcd == 8'h80));
  endtask

  initial begin
    int vhi;
    logic [7:0] rm, rc;
    b0.in_valid = 1'b0; b0.multiplier = '0; b0.multiplicand = '0; b0.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready1", 32'(b0.in_ready), 32'd0);
    chk("rst in_ready2", 32'(b1.in_ready), 32'd0);
    chk("rst out_valid", 32'({b0.out_valid, b1.out_valid}), 32'd0);
    chk("rst busy", 32'({b0.busy, b1.busy}), 32'd0);
    chk("rst product1", 32'(b0.product), 32'd0);
    chk("rst product2", 32'(b1.product), 32'd0);
    chk("rst err", 32'({b0.out_err, b1.out_err}), 32'd0);
    rst = 1'b0;
    #1;

    op(8'd3, 8'd5, "3x5");
    op(8'hF9, 8'h06, "-7x6");
    op(8'h80, 8'h7F, "-128x127");
    op(8'hFF, 8'hFF, "-1x-1");
    op(8'd5, 8'h80, "5x-128");
    op(8'd3, 8'd5, "3x5 after err");

    // Backpressure: hold result for 20 clocks while a stray request is offered.
    b0.out_ready = 1'b0;
    b0.in_valid = 1'b1; b0.multiplier = 8'hFF; b0.multiplicand = 8'hFF;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin b0.in_valid = 1'b1; b0.multiplier = 8'd3; b0.multiplicand = 8'd5; end
      if (i == 15) b0.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp out_valid", 32'({b0.out_valid, b1.out_valid}), 32'd3);
      chk("bp product1", 32'(b0.product), 32'h0001);
      chk("bp product2", 32'(b1.product), 32'h0001);
      chk("bp in_ready", 32'({b0.in_ready, b1.in_ready}), 32'd0);
    end
    b0.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", 32'({b0.in_ready, b1.in_ready}), 32'd3);
    chk("bp release out_valid", 32'({b0.out_valid, b1.out_valid}), 32'd0);
    chk("bp release busy", 32'({b0.busy, b1.busy}), 32'd0);
    chk("bp hold product1", 32'(b0.product), 32'h0001);

    // Reset during RUN: three substeps applied, rst sampled on the fourth edge.
    b0.in_valid = 1'b1; b0.multiplier = 8'd3; b0.multiplicand = 8'd5;
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort product1", 32'(b0.product), 32'd0);
    chk("abort product2", 32'(b1.product), 32'd0);
    chk("abort busy", 32'({b0.busy, b1.busy}), 32'd0);
    chk("abort in_ready", 32'({b0.in_ready, b1.in_ready}), 32'd3);
    vhi = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (b0.out_valid || b1.out_valid) vhi++;
    end
    chk("abort no out_valid", 32'(vhi), 32'd0);
    op(8'd2, 8'd2, "2x2");

    op(8'd0, 8'd9, "0x9");
    op(8'd9, 8'd0, "9x0");
    op(8'h80, 8'h80, "-128x-128");

    for (int n = 0; n < 20; n++) begin
      rm = 8'($urandom);
      rc = 8'($urandom_range(0, 255));
      if (rc == 8'h80) rc = 8'h7F;
      op(rm, rc, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
